piso_shift_out: RTL



---
 rtl/piso_shift_out_pkg.sv | 12 +
 rtl/piso_shift_out_bit_counter.sv | 20 ++
 rtl/piso_shift_out.sv | 76 +++++++
 3 files changed

// File: rtl/piso_shift_out_pkg.sv
// piso_shift_out_pkg: FSM state encoding and beat count for the PISO transmitter.
// Defining PISO_PARITY_EN adds one even-parity beat after the LSB.
package piso_shift_out_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_e;
  function automatic int nbits(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction
endpackage

// File: rtl/piso_shift_out_bit_counter.sv
// piso_bit_counter: synchronous-reset up-counter with a flag on the final beat (count == N-1).
module piso_bit_counter #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   inc,
  output logic [$clog2(N+1)-1:0] count,
  output logic                   last
);
  localparam int CW = $clog2(N + 1);
  logic [CW-1:0] count_q;
  always_ff @(posedge clk) begin
    if (reset || clear) count_q <= '0;
    else if (inc) count_q <= count_q + CW'(1);
  end
  assign count = count_q;
  assign last  = count_q == CW'(N - 1);
endmodule

// File: rtl/piso_shift_out.sv
// piso_shift_out: loads a WIDTH-bit word and shifts it out MSB-first under a valid/ready beat.
// PISO_PARITY_EN appends an even-parity beat after the LSB.
module piso_shift_out
  import piso_shift_out_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_valid,
  output logic             ser_out,
  input  logic             ser_ready,
  output logic             done
);
  localparam int NBITS = nbits(WIDTH);
  localparam int CW = $clog2(NBITS + 1);
  state_e           state_q;
  logic [NBITS-1:0] sh_q;
  logic             ser_valid_q, done_q, load_ready_q;
  logic [NBITS-1:0] load_word;
  logic [CW-1:0]    cnt;
  logic             last, unused_cnt;
`ifdef PISO_PARITY_EN
  assign load_word = {load_data, ^load_data};
`else
  assign load_word = load_data;
`endif
  piso_bit_counter #(.N(NBITS)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(state_q == S_IDLE && load_valid),
    .inc  (state_q == S_SHIFT && ser_ready),
    .count(cnt),
    .last (last)
  );
  assign unused_cnt = ^cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sh_q         <= '0;
      ser_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (load_valid) begin
          sh_q         <= load_word;
          state_q      <= S_SHIFT;
          ser_valid_q  <= 1'b1;
          load_ready_q <= 1'b0;
        end
        S_SHIFT: if (ser_ready) begin
          sh_q <= sh_q << 1;
          if (last) begin
            state_q     <= S_DONE;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        S_DONE: begin
          done_q       <= 1'b0;
          load_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign load_ready = load_ready_q;
  assign ser_valid  = ser_valid_q;
  assign done       = done_q;
  assign ser_out    = ser_valid_q & sh_q[NBITS-1];
endmodule
